// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and baud divider arithmetic.
`timescale 1ns/1ps
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_STOP      = 3'd3,
    RX_WAIT_HIGH = 3'd4
  } rx_state_t;

  // Clocks per sample tick, rounded to nearest: round(clk / (baud * oversample)).
  function automatic int unsigned tick_div(input int unsigned clk_hz,
                                           input int unsigned baud,
                                           input int unsigned oversample);
    int unsigned den;
    den = baud * oversample;
    return (clk_hz + den / 2) / den;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Sample-tick generator: one-cycle tick every TICK_DIV clocks, re-phased by restart.
`timescale 1ns/1ps
module uart_baud_gen #(
  parameter int unsigned TICK_DIV = 54
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             r_tick;

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (r_cnt == CNT_W'(TICK_DIV - 1)) begin
      r_cnt  <= '0;
      r_tick <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + 1'b1;
      r_tick <= 1'b0;
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 2-of-3 majority sampling, early stop-bit return and break handling.
`timescale 1ns/1ps
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned BAUD_RATE   = 115_200,
  parameter int unsigned OVERSAMPLE  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_in_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int unsigned TICK_DIV = tick_div(CLK_FREQ_HZ, BAUD_RATE, OVERSAMPLE);
  localparam int unsigned IDX_W    = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W    = $clog2(DATA_BITS);

  localparam logic [IDX_W-1:0] IDX_S0   = IDX_W'(OVERSAMPLE / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_S1   = IDX_W'(OVERSAMPLE / 2);
  localparam logic [IDX_W-1:0] IDX_S2   = IDX_W'(OVERSAMPLE / 2 + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  logic                 r_rx_meta;
  logic                 r_rx_s;
  logic [1:0]           r_flush;
  logic                 r_seen_high;
  rx_state_t            r_state;
  logic [IDX_W-1:0]     r_tick_idx;
  logic [BIT_W-1:0]     r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic [1:0]           r_samp;
  logic [DATA_BITS-1:0] r_data_out;
  logic                 r_valid;
  logic                 r_ferr;
  logic                 r_busy;

  logic w_tick;
  logic w_restart;
  logic w_maj;
  logic w_decide;
  logic w_wrap;

  // Start edge only counts once the line has genuinely been seen idle after reset.
  assign w_restart = (r_state == RX_IDLE) && !r_rx_s && r_seen_high;

  // Third vote is the live synchronized sample at the decision tick.
  assign w_maj    = (r_samp[0] & r_samp[1]) | (r_samp[0] & r_rx_s) | (r_samp[1] & r_rx_s);
  assign w_decide = w_tick && (r_tick_idx == IDX_S2);
  assign w_wrap   = w_tick && (r_tick_idx == IDX_LAST);

  uart_baud_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_baud_gen (
    .clk     (clk),
    .rst     (rst),
    .restart (w_restart),
    .tick    (w_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta   <= 1'b1;
      r_rx_s      <= 1'b1;
      r_flush     <= 2'd0;
      r_seen_high <= 1'b0;
      r_state     <= RX_IDLE;
      r_tick_idx  <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_samp      <= 2'b11;
      r_data_out  <= '0;
      r_valid     <= 1'b0;
      r_ferr      <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;

      // Reset values still occupy the synchronizer for two cycles; ignore them.
      if (r_flush != 2'd2) r_flush <= r_flush + 2'd1;
      if (r_flush == 2'd2 && r_rx_s) r_seen_high <= 1'b1;

      if (w_tick) begin
        r_tick_idx <= (r_tick_idx == IDX_LAST) ? '0 : r_tick_idx + 1'b1;
        if (r_tick_idx == IDX_S0) r_samp[0] <= r_rx_s;
        if (r_tick_idx == IDX_S1) r_samp[1] <= r_rx_s;
      end

      case (r_state)
        RX_IDLE: begin
          if (w_restart) begin
            r_state    <= RX_START;
            r_tick_idx <= '0;
            r_busy     <= 1'b1;
          end
        end
        RX_START: begin
          if (w_decide && w_maj) begin
            r_state <= RX_IDLE;
            r_busy  <= 1'b0;
          end else if (w_wrap) begin
            r_state   <= RX_DATA;
            r_bit_cnt <= '0;
          end
        end
        RX_DATA: begin
          if (w_decide) r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
          if (w_wrap) begin
            if (r_bit_cnt == BIT_LAST) r_state <= RX_STOP;
            else r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (w_decide) begin
            if (w_maj) begin
              r_data_out <= r_shift;
              r_valid    <= 1'b1;
              r_state    <= RX_IDLE;
              r_busy     <= 1'b0;
            end else begin
              r_ferr  <= 1'b1;
              r_state <= RX_WAIT_HIGH;
            end
          end
        end
        RX_WAIT_HIGH: begin
          if (r_rx_s) begin
            r_state <= RX_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= RX_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign data_out      = r_data_out;
  assign data_in_valid = r_valid;
  assign frame_err     = r_ferr;
  assign busy          = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: serial frames against a byte/frame-error reference model.
`timescale 1ns/1ps
module tb_uart_rx;

  // 100 MHz / (781_250 * 16) divides exactly by 8, so one bit is 1280 ns.
  localparam int unsigned BAUD   = 781_250;
  localparam int          BIT_NS = 1280;
  localparam int          TICKNS = BIT_NS / 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] data_out;
  logic       data_in_valid;
  logic       frame_err;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  uart_rx #(
    .CLK_FREQ_HZ (100_000_000),
    .BAUD_RATE   (BAUD),
    .OVERSAMPLE  (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rx            (rx),
    .data_out      (data_out),
    .data_in_valid (data_in_valid),
    .frame_err     (frame_err),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // Observed traffic
  logic [7:0] rx_q[$];
  longint     vtime_q[$];
  int         ferr_cnt     = 0;
  int         both_cnt     = 0;
  int         long_cnt     = 0;
  int         unstable_cnt = 0;
  logic       prev_v = 1'b0, prev_f = 1'b0;
  logic [7:0] prev_d = 8'h00;

  always @(negedge clk) begin
    if (data_in_valid === 1'b1) begin
      rx_q.push_back(data_out);
      vtime_q.push_back(longint'($time));
    end
    if (frame_err === 1'b1) ferr_cnt++;
    if (data_in_valid === 1'b1 && frame_err === 1'b1) both_cnt++;
    if ((data_in_valid === 1'b1 && prev_v) || (frame_err === 1'b1 && prev_f)) long_cnt++;
    if (rst === 1'b0 && data_in_valid !== 1'b1 && data_out !== prev_d) unstable_cnt++;
    prev_v = (data_in_valid === 1'b1);
    prev_f = (frame_err === 1'b1);
    prev_d = data_out;
  end

  // Reference model: bytes with a good stop bit are expected, bad stop bits count as errors
  logic [7:0] exp_q[$];
  int         exp_ferr = 0;
  logic [7:0] exp_last = 8'h00;

  task automatic clear_model();
    rx_q.delete();
    vtime_q.delete();
    exp_q.delete();
    ferr_cnt = 0;
    exp_ferr = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok, input int glitch_bit);
    rx = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      if (i == glitch_bit) begin
        #(9 * TICKNS - 20);
        rx = ~b[i];
        #(TICKNS);
        rx = b[i];
        #(BIT_NS - 10 * TICKNS + 20);
      end else begin
        #(BIT_NS);
      end
    end
    rx = stop_ok;
    #(BIT_NS);
    if (stop_ok) begin
      exp_q.push_back(b);
      exp_last = b;
    end else begin
      exp_ferr++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL reset_data_out got=%h exp=00", data_out); end
    checks++; if (data_in_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", data_in_valid); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    // Line stuck low out of reset must not start a frame.
    rst = 1'b0;
    #(2 * BIT_NS);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL stuck_low_busy got=%b exp=0", busy); end
    rx = 1'b1;
    #(2 * BIT_NS);
    checks++; if (rx_q.size() != 0 || ferr_cnt != 0) begin failures++; $display("FAIL stuck_low_pulses got=%0d/%0d exp=0/0", rx_q.size(), ferr_cnt); end
  endtask

  task automatic test_single();
    longint t0;
    clear_model();
    @(negedge clk);
    t0 = longint'($time);
    send_byte(8'h55, 1'b1, -1);
    #(BIT_NS);
    checks++; if (rx_q.size() != 1) begin failures++; $display("FAIL single_count got=%0d exp=1", rx_q.size()); end
    if (rx_q.size() > 0) begin
      checks++; if (rx_q[0] !== exp_q[0]) begin failures++; $display("FAIL single_data got=%h exp=%h", rx_q[0], exp_q[0]); end
      checks++;
      if (vtime_q[0] - t0 < longint'(9 * BIT_NS) || vtime_q[0] - t0 > longint'(10 * BIT_NS)) begin
        failures++; $display("FAIL single_latency got=%0d ns exp=%0d..%0d", vtime_q[0] - t0, 9 * BIT_NS, 10 * BIT_NS);
      end
    end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy got=%b exp=0", busy); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [3] = '{8'hA5, 8'h00, 8'hFF};
    logic [7:0] got;
    clear_model();
    @(negedge clk);
    for (int i = 0; i < 3; i++) send_byte(bytes[i], 1'b1, -1);
    #(BIT_NS);
    checks++; if (rx_q.size() != 3) begin failures++; $display("FAIL b2b_count got=%0d exp=3", rx_q.size()); end
    for (int i = 0; i < 3; i++) begin
      got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
      checks++; if (got !== exp_q[i]) begin failures++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, got, exp_q[i]); end
    end
    checks++; if (ferr_cnt != 0) begin failures++; $display("FAIL b2b_frame_err got=%0d exp=0", ferr_cnt); end
  endtask

  task automatic test_false_start();
    clear_model();
    @(negedge clk);
    rx = 1'b0;
    #200;
    rx = 1'b1;
    #(BIT_NS);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL false_start_busy got=%b exp=0", busy); end
    checks++; if (rx_q.size() != 0 || ferr_cnt != 0) begin failures++; $display("FAIL false_start_pulses got=%0d/%0d exp=0/0", rx_q.size(), ferr_cnt); end
  endtask

  task automatic test_frame_error();
    logic [7:0] got;
    clear_model();
    @(negedge clk);
    send_byte(8'h3C, 1'b0, -1);
    #(3 * BIT_NS);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL break_busy got=%b exp=1", busy); end
    rx = 1'b1;
    #(2 * BIT_NS);
    checks++; if (ferr_cnt != exp_ferr) begin failures++; $display("FAIL ferr_count got=%0d exp=%0d", ferr_cnt, exp_ferr); end
    checks++; if (data_out !== exp_last) begin failures++; $display("FAIL ferr_data_held got=%h exp=%h", data_out, exp_last); end
    checks++; if (rx_q.size() != 0) begin failures++; $display("FAIL ferr_no_valid got=%0d exp=0", rx_q.size()); end
    send_byte(8'h81, 1'b1, -1);
    #(BIT_NS);
    got = (rx_q.size() == 1) ? rx_q[0] : 8'hxx;
    checks++; if (got !== 8'h81) begin failures++; $display("FAIL after_ferr_data got=%h count=%0d exp=81", got, rx_q.size()); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    logic [7:0] got;
    b = 8'h96;
    clear_model();
    @(negedge clk);
    rx = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 4; i++) begin rx = b[i]; #(BIT_NS); end
    rx = b[4];
    #(BIT_NS / 2);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    checks++; if (data_out !== 8'h00 || busy !== 1'b0 || data_in_valid !== 1'b0 || frame_err !== 1'b0) begin
      failures++; $display("FAIL mid_reset_outputs got=%h/%b/%b/%b exp=00/0/0/0", data_out, busy, data_in_valid, frame_err);
    end
    rst = 1'b0;
    exp_last = 8'h00;
    rx = 1'b1;
    #(2 * BIT_NS);
    checks++; if (rx_q.size() != 0 || ferr_cnt != 0) begin failures++; $display("FAIL mid_reset_pulses got=%0d/%0d exp=0/0", rx_q.size(), ferr_cnt); end
    @(negedge clk);
    send_byte(8'h42, 1'b1, -1);
    #(BIT_NS);
    got = (rx_q.size() == 1) ? rx_q[0] : 8'hxx;
    checks++; if (got !== 8'h42) begin failures++; $display("FAIL post_reset_data got=%h count=%0d exp=42", got, rx_q.size()); end
  endtask

  task automatic test_glitch();
    logic [7:0] got;
    clear_model();
    @(negedge clk);
    send_byte(8'hC3, 1'b1, 2);
    send_byte(8'hC3, 1'b1, 0);
    #(BIT_NS);
    for (int i = 0; i < 2; i++) begin
      got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
      checks++; if (got !== 8'hC3) begin failures++; $display("FAIL glitch_data[%0d] got=%h exp=c3", i, got); end
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    logic [7:0] got;
    bit         ok;
    clear_model();
    @(negedge clk);
    for (int n = 0; n < 10; n++) begin
      b  = 8'($urandom);
      ok = ($urandom_range(0, 3) != 0);
      send_byte(b, ok, ok ? int'($urandom_range(0, 9)) - 2 : -1);
      if (!ok) begin rx = 1'b1; #(BIT_NS); end
      else if ($urandom_range(0, 1) == 1) #(BIT_NS);
    end
    #(BIT_NS);
    checks++; if (rx_q.size() != exp_q.size()) begin failures++; $display("FAIL rand_count got=%0d exp=%0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
      checks++; if (got !== exp_q[i]) begin failures++; $display("FAIL rand_data[%0d] got=%h exp=%h", i, got, exp_q[i]); end
    end
    checks++; if (ferr_cnt != exp_ferr) begin failures++; $display("FAIL rand_ferr got=%0d exp=%0d", ferr_cnt, exp_ferr); end
    checks++; if (data_out !== exp_last) begin failures++; $display("FAIL rand_last_data got=%h exp=%h", data_out, exp_last); end
  endtask

  task automatic test_pulse_rules();
    checks++; if (both_cnt != 0) begin failures++; $display("FAIL valid_and_ferr_together got=%0d exp=0", both_cnt); end
    checks++; if (long_cnt != 0) begin failures++; $display("FAIL pulse_width got=%0d long pulses exp=0", long_cnt); end
    checks++; if (unstable_cnt != 0) begin failures++; $display("FAIL data_out_stability got=%0d changes exp=0", unstable_cnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_false_start();
    test_frame_error();
    test_reset_mid_frame();
    test_glitch();
    test_random();
    test_pulse_rules();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
